// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2^INDEX_BITS two-bit saturating counters indexed by pc[INDEX_BITS+1:2].
// Define BP_STATS_EN to add the stat_branches / stat_mispredicts counters.
module branch_predictor #(
    parameter int         INDEX_BITS  = 6,
    parameter logic [1:0] RESET_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    output logic        f_pred_taken,
    input  logic        d_valid,
    input  logic        d_is_branch,
    input  logic [31:0] d_pc,
    input  logic        d_pred_taken,
    input  logic        d_actual_taken,
    output logic        d_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // f_valid and d_valid are plain qualifiers with no back-pressure: a lookup or an
    // update happens in exactly the cycle its valid is high; there is no ready.
    logic [1:0]            ctr_q [ENTRIES];
    logic [INDEX_BITS-1:0] f_idx;
    logic [INDEX_BITS-1:0] d_idx;
    logic                  update;
    logic [1:0]            cur_ctr;
    logic [1:0]            next_ctr;
    logic                  unused_pc_bits;

    assign f_idx  = f_pc[INDEX_BITS+1:2];
    assign d_idx  = d_pc[INDEX_BITS+1:2];
    assign update = d_valid & d_is_branch;

    // Upper PC bits are untagged (aliasing allowed); byte-offset bits never matter.
    assign unused_pc_bits = ^{f_pc[31:INDEX_BITS+2], f_pc[1:0],
                              d_pc[31:INDEX_BITS+2], d_pc[1:0]};

    // Gate with a mux rather than AND so an unknown index cannot leak out when idle.
    always_comb begin
        f_pred_taken = 1'b0;
        if (f_valid) begin
            f_pred_taken = ctr_q[f_idx][1];
        end
    end

    assign d_mispredict = d_valid & d_is_branch & (d_pred_taken != d_actual_taken);

    always_comb begin
        cur_ctr  = ctr_q[d_idx];
        next_ctr = cur_ctr;
        if (d_actual_taken) begin
            if (cur_ctr != 2'b11) begin
                next_ctr = cur_ctr + 2'd1;
            end
        end else begin
            if (cur_ctr != 2'b00) begin
                next_ctr = cur_ctr - 2'd1;
            end
        end
    end

    // Lookups read ctr_q directly, so a same-cycle update is seen only from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= RESET_STATE;
            end
        end else if (update) begin
            ctr_q[d_idx] <= next_ctr;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (update) begin
            stat_branches <= stat_branches + 32'd1;
            if (d_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule
